// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, register-index
// width and the per-stage stall/flush control bundle.
package pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FREEZE = 2'd2
    } haz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exmem_stall;
        logic ifid_flush;
        logic idex_flush;
    } haz_ctl_t;

    localparam haz_ctl_t CTL_NONE   = haz_ctl_t'(6'b00_0000);
    localparam haz_ctl_t CTL_LU     = haz_ctl_t'(6'b11_0001);
    localparam haz_ctl_t CTL_FREEZE = haz_ctl_t'(6'b11_1100);
    localparam haz_ctl_t CTL_REDIR  = haz_ctl_t'(6'b00_0011);

    // Saturating 32-bit increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            return val;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/haz_lu_detect.sv
// Load-use comparator: flags an ID-stage read of the register a load in EX is
// about to write. x0 never creates a hazard.
import pipe_pkg::*;

module haz_lu_detect (
    input  logic                 ex_memRead,
    input  logic [REG_IDX_W-1:0] ex_RegRd,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic                 id_rs1_use,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs2_use,
    output logic                 lu_hit
);

    logic rs1_match_s;
    logic rs2_match_s;

    assign rs1_match_s = id_rs1_use & (id_rs1 == ex_RegRd);
    assign rs2_match_s = id_rs2_use & (id_rs2 == ex_RegRd);
    assign lu_hit      = ex_memRead & (ex_RegRd != {REG_IDX_W{1'b0}}) & (rs1_match_s | rs2_match_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect squash and memory freeze.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush/freeze event counters.
import pipe_pkg::*;

module pipe_hazard_ctrl #(
    parameter int LU_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_use,
    input  logic                 id_rs2_use,
    input  logic                 ex_memRead,
    input  logic [REG_IDX_W-1:0] ex_RegRd,
    input  logic                 ex_redirect,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 idex_stall,
    output logic                 exmem_stall,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 mem_timeout,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_events,
    output logic [31:0]          freeze_cycles,
`endif
    output logic                 busy
);

    localparam logic [1:0]  LU_RELOAD = 2'(LU_BUBBLES - 1);
    localparam logic [15:0] TMO_LIMIT = 16'(MEM_TIMEOUT);

    haz_state_t  state_r;
    haz_state_t  state_s;
    haz_state_t  eff_state_s;
    logic [1:0]  bub_cnt_r;
    logic [1:0]  bub_cnt_s;
    logic [15:0] tmo_cnt_r;
    logic [15:0] tmo_cnt_s;
    logic        mem_timeout_r;
    logic        mem_timeout_s;
    logic        freeze_cond_s;
    logic        lu_hit_s;
    haz_ctl_t    ctl_s;

    assign freeze_cond_s = mem_req & ~mem_ready;

    haz_lu_detect u_lu_detect (
        .ex_memRead (ex_memRead),
        .ex_RegRd   (ex_RegRd),
        .id_rs1     (id_rs1),
        .id_rs1_use (id_rs1_use),
        .id_rs2     (id_rs2),
        .id_rs2_use (id_rs2_use),
        .lu_hit     (lu_hit_s)
    );

    // Release cycle of a freeze behaves as the state that was frozen; the held
    // bubble count tells which one it was.
    always_comb begin
        case (state_r)
            RUN:     eff_state_s = RUN;
            BUBBLE:  eff_state_s = BUBBLE;
            FREEZE:  eff_state_s = (bub_cnt_r != 2'd0) ? BUBBLE : RUN;
            default: eff_state_s = RUN;
        endcase
    end

    // Next-state, counter and control evaluation with freeze > redirect > load-use.
    always_comb begin
        ctl_s         = CTL_NONE;
        state_s       = state_r;
        bub_cnt_s     = bub_cnt_r;
        tmo_cnt_s     = 16'd0;
        mem_timeout_s = mem_timeout_r;
        if (freeze_cond_s) begin
            ctl_s     = CTL_FREEZE;
            state_s   = FREEZE;
            tmo_cnt_s = (tmo_cnt_r != 16'hFFFF) ? (tmo_cnt_r + 16'd1) : tmo_cnt_r;
            if (tmo_cnt_s >= TMO_LIMIT) begin
                mem_timeout_s = 1'b1;
            end else begin
                mem_timeout_s = mem_timeout_r;
            end
        end else if (ex_redirect) begin
            ctl_s     = CTL_REDIR;
            state_s   = RUN;
            bub_cnt_s = 2'd0;
        end else begin
            case (eff_state_s)
                RUN: begin
                    if (lu_hit_s) begin
                        ctl_s = CTL_LU;
                        if (LU_BUBBLES > 1) begin
                            state_s   = BUBBLE;
                            bub_cnt_s = LU_RELOAD;
                        end else begin
                            state_s   = RUN;
                            bub_cnt_s = 2'd0;
                        end
                    end else begin
                        ctl_s     = CTL_NONE;
                        state_s   = RUN;
                        bub_cnt_s = 2'd0;
                    end
                end
                BUBBLE: begin
                    ctl_s = CTL_LU;
                    if (bub_cnt_r <= 2'd1) begin
                        state_s   = RUN;
                        bub_cnt_s = 2'd0;
                    end else begin
                        state_s   = BUBBLE;
                        bub_cnt_s = bub_cnt_r - 2'd1;
                    end
                end
                default: begin
                    ctl_s     = CTL_NONE;
                    state_s   = RUN;
                    bub_cnt_s = 2'd0;
                end
            endcase
        end
    end

    // Output drive; everything is forced quiet while reset is held.
    always_comb begin
        if (rst) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            idex_stall  = 1'b0;
            exmem_stall = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            mem_timeout = 1'b0;
            busy        = 1'b0;
        end else begin
            pc_stall    = ctl_s.pc_stall;
            ifid_stall  = ctl_s.ifid_stall;
            idex_stall  = ctl_s.idex_stall;
            exmem_stall = ctl_s.exmem_stall;
            ifid_flush  = ctl_s.ifid_flush;
            idex_flush  = ctl_s.idex_flush;
            mem_timeout = mem_timeout_r;
            busy        = (state_r != RUN);
        end
    end

    // State, bubble/timeout counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            bub_cnt_r     <= 2'd0;
            tmo_cnt_r     <= 16'd0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            bub_cnt_r     <= bub_cnt_s;
            tmo_cnt_r     <= tmo_cnt_s;
            mem_timeout_r <= mem_timeout_s;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_events_r;
    logic [31:0] freeze_cycles_r;

    // Saturating event counters for stalls, flushes and frozen cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r  <= 32'd0;
            flush_events_r  <= 32'd0;
            freeze_cycles_r <= 32'd0;
        end else begin
            stall_cycles_r  <= ctl_s.pc_stall ? sat_inc32(stall_cycles_r) : stall_cycles_r;
            flush_events_r  <= (ctl_s.ifid_flush | ctl_s.idex_flush) ? sat_inc32(flush_events_r) : flush_events_r;
            freeze_cycles_r <= freeze_cond_s ? sat_inc32(freeze_cycles_r) : freeze_cycles_r;
        end
    end

    assign stall_cycles  = stall_cycles_r;
    assign flush_events  = flush_events_r;
    assign freeze_cycles = freeze_cycles_r;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. Generates per-stage stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers from decode-stage register usage, execute-stage load/branch status and the data-memory handshake. It inserts multi-cycle load-use bubbles, squashes wrong-path instructions on taken branches and jumps, and freezes the whole pipe while data memory is busy.

## Interface
- LU_BUBBLES, 1, bubble cycles inserted per load-use hazard (1..3)
- MEM_TIMEOUT, 255, freeze cycles before mem_timeout is flagged (1..65535)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_use, id_rs2_use  in  1 each  source actually read by the ID instruction
- ex_memRead  in  1  instruction in EX is a load
- ex_RegRd  in  5  destination register of the EX instruction
- ex_redirect  in  1  EX branch taken or jump; PC is redirected this cycle
- mem_req  in  1  MEM stage is issuing a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the register
- ifid_flush, idex_flush  out  1 each  load a bubble into the register (all zero)
- mem_timeout  out  1  sticky: freeze exceeded MEM_TIMEOUT
- busy  out  1  state != RUN

## Operation
- States: RUN, BUBBLE, FREEZE. Reset: state RUN, bubble counter 0, timeout counter 0, mem_timeout 0. All outputs are 0 while rst is high.
- freeze_cond = mem_req & ~mem_ready. lu_hit = ex_memRead & (ex_RegRd != 0) & ((id_rs1_use & id_rs1 == ex_RegRd) | (id_rs2_use & id_rs2 == ex_RegRd)).
- Priority, evaluated every cycle: freeze > redirect > load-use.
- FREEZE (entered from any state when freeze_cond): pc/ifid/idex/exmem stall = 1, all flushes = 0. The bubble counter holds its value. Exit on the cycle in which mem_ready = 1; that cycle is evaluated as the pre-freeze state (RUN, or BUBBLE with the held count).
- Redirect (ex_redirect, no freeze): ifid_flush = idex_flush = 1, no stalls. Any BUBBLE in progress is cancelled and the counter is cleared. Next state RUN.
- Load-use in RUN (lu_hit, no freeze/redirect): pc_stall = ifid_stall = 1, idex_flush = 1. If LU_BUBBLES > 1, go to BUBBLE with counter = LU_BUBBLES-1. Otherwise stay in RUN.
- BUBBLE: same outputs as load-use. The counter decrements each non-frozen cycle. Return to RUN on the cycle the counter reaches 0. lu_hit is ignored in BUBBLE.
- Timeout counter: 16-bit. Increments each FREEZE cycle and clears on FREEZE exit. When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until rst. The freeze continues.

## Timing
- All stall/flush outputs are combinational from the current state and inputs, valid in the same cycle as the hazard. State, counters and mem_timeout are registered on posedge clk.
- Load-use costs exactly LU_BUBBLES cycles, plus any freeze cycles.
- Redirect costs exactly 2 squashed instructions.
- Freeze adds exactly N cycles for N cycles of mem_req & ~mem_ready.
- Redirect arriving during FREEZE takes effect on the release cycle, because EX is held and re-presents it.
- rst asserted in any state returns to RUN on the next edge and clears all counters.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - Adds outputs stall_cycles, flush_events, freeze_cycles (32 bits each, saturating at all-ones, cleared by rst).
  - stall_cycles counts cycles with pc_stall = 1.
  - flush_events counts cycles with ifid_flush or idex_flush = 1.
  - freeze_cycles counts cycles in the FREEZE state.
- HAZ_PERF_CNT_EN undefined: these ports and counters are absent. The remaining behaviour is identical.

## Structure
- Shared package pipe_pkg: state enum haz_state_t {RUN, BUBBLE, FREEZE}, register-index width constant REG_IDX_W = 5, stall/flush struct haz_ctl_t.
- One sub-module: haz_lu_detect (combinational lu_hit comparator), reusable by the forwarding unit.

## Test plan
- LU_BUBBLES=1, load x5 in EX, ID reads x5 via rs2 -> one cycle of pc_stall=ifid_stall=idex_flush=1, then RUN.
- Load with RegRd=x0 in EX, ID reads x0 -> no stall.
- LU_BUBBLES=3 load-use, mem_req&~mem_ready for 2 cycles in the middle bubble -> 3 bubble cycles + 2 freeze cycles; flushes are 0 during the freeze.
- ex_redirect and lu_hit in the same cycle -> ifid_flush=idex_flush=1, no stall, next state RUN.
- MEM_TIMEOUT=4, mem_ready held low for 6 cycles -> mem_timeout rises once the timeout counter reaches 4, freeze held for 6 cycles, mem_timeout stays 1 after release until rst.
- rst asserted during BUBBLE with counter 2 -> next cycle state RUN, all outputs 0, counters 0.
